// File: rtl/rtc_write_sequencer_if.sv
// rtc_write_sequencer_if: RTC multiplexed address/data pin bundle
interface rtc_write_sequencer_if;
  logic [7:0] bus_out;
  logic bus_oe, ad_sel, cs_n, wr_n, rd_n;
  modport master(output bus_out, bus_oe, ad_sel, cs_n, wr_n, rd_n);
  modport slave(input bus_out, bus_oe, ad_sel, cs_n, wr_n, rd_n);
endinterface

// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer: writes nine time/date registers plus a transfer command over the RTC A/D bus
module rtc_write_sequencer #(
  parameter int T_STROBE = 4,
  parameter logic [7:0] CMD = 8'hF0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [7:0] data_in,
  output logic [3:0] sel_reg,
  output logic busy,
  output logic done,
  rtc_write_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  localparam logic [3:0] LAST = 4'(T_STROBE - 1);
  state_t state, state_n;
  logic [3:0] item, item_n, cnt, cnt_n, addr_n;
  logic phase, phase_n, drive_n;
  logic [7:0] data, data_n;
  always_comb begin
    state_n = state;
    item_n = item;
    phase_n = phase;
    cnt_n = cnt;
    data_n = data;
    case (state)
      IDLE: if (start) begin
        state_n = SETUP;
        item_n = 4'd0;
        phase_n = 1'b0;
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n = 4'd0;
      end
      STROBE: if (cnt == LAST) state_n = HOLD; else cnt_n = cnt + 4'd1;
      HOLD: if (!phase) begin
        state_n = SETUP;
        phase_n = 1'b1;
        data_n = item == 4'd9 ? CMD : data_in;
      end else if (item != 4'd9) begin
        state_n = SETUP;
        phase_n = 1'b0;
        item_n = item + 4'd1;
      end else state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // Pins are registered from the next-state view so they line up with the state they describe.
  assign drive_n = state_n == SETUP || state_n == STROBE || state_n == HOLD;
  assign addr_n = item_n == 4'd9 ? 4'hD : 4'h4 + item_n;
  assign bus.rd_n = 1'b1;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      item <= 4'd0;
      phase <= 1'b0;
      cnt <= 4'd0;
      data <= 8'h00;
      sel_reg <= 4'h0;
      busy <= 1'b0;
      done <= 1'b0;
      bus.bus_out <= 8'h00;
      bus.bus_oe <= 1'b0;
      bus.ad_sel <= 1'b0;
      bus.cs_n <= 1'b1;
      bus.wr_n <= 1'b1;
    end else begin
      state <= state_n;
      item <= item_n;
      phase <= phase_n;
      cnt <= cnt_n;
      data <= data_n;
      sel_reg <= item_n == 4'd9 ? 4'hF : item_n;
      busy <= drive_n;
      done <= state_n == DONE;
      bus.bus_out <= !drive_n ? 8'h00 : phase_n ? data_n : {4'h0, addr_n};
      bus.bus_oe <= drive_n;
      bus.ad_sel <= drive_n && phase_n;
      bus.cs_n <= state_n != STROBE;
      bus.wr_n <= state_n != STROBE;
    end
  end
endmodule

// File: tb/tb_rtc_write_sequencer.sv
// tb_rtc_write_sequencer: directed checks of write bursts at strobe widths 4, 1 and 15
module tb_rtc_write_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] st = 3'b000;
  logic ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'hA5;
  logic [2:0] cs_w, wr_w, rd_w, oe_w, ad_w, busy_w, done_w;
  logic [7:0] bus_w [3];
  logic [3:0] sel_w [3];
  logic [7:0] din [3];
  int n_chk = 0, n_fail = 0, m = 0;
  logic clr = 1'b0;
  int cyc, ns, w, ndone, tfirst, tdone, stab_bad, rd_bad, wr_bad;
  logic [8:0] cap [20];
  int wid [20];
  logic [8:0] cur, prev_val;
  logic prev_cs = 1'b1, prev_busy = 1'b0, prev_oe = 1'b0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g
    rtc_write_sequencer_if bus ();
    rtc_write_sequencer #(.T_STROBE(i == 0 ? 4 : (i == 1 ? 1 : 15))) dut (
      .clk(clk), .reset(rst_n), .start(st[i]), .data_in(din[i]),
      .sel_reg(sel_w[i]), .busy(busy_w[i]), .done(done_w[i]), .bus(bus.master));
    assign din[i] = (i == 0 && ovr_en) ? ovr_val : 8'h10 + {4'h0, sel_w[i]};
    assign cs_w[i] = bus.cs_n;
    assign wr_w[i] = bus.wr_n;
    assign rd_w[i] = bus.rd_n;
    assign oe_w[i] = bus.bus_oe;
    assign ad_w[i] = bus.ad_sel;
    assign bus_w[i] = bus.bus_out;
  end

  // Strobe monitor on the selected DUT: captures {ad_sel, bus} per strobe and its low width.
  always @(negedge clk) begin
    if (clr) begin
      cyc <= 0; ns <= 0; w <= 0; ndone <= 0; tfirst <= -1; tdone <= -1;
      stab_bad <= 0; rd_bad <= 0; wr_bad <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!cs_w[m]) begin
        if (prev_cs) begin
          cur <= {ad_w[m], bus_w[m]};
          w <= 1;
          if (!prev_oe || prev_val != {ad_w[m], bus_w[m]}) stab_bad <= stab_bad + 1;
        end else begin
          w <= w + 1;
          if ({ad_w[m], bus_w[m]} != cur) stab_bad <= stab_bad + 1;
        end
      end else if (!prev_cs) begin
        if (ns < 20) begin
          cap[ns] <= cur;
          wid[ns] <= w;
        end
        ns <= ns + 1;
        if (!oe_w[m] || {ad_w[m], bus_w[m]} != cur) stab_bad <= stab_bad + 1;
      end
      if (rd_w[m] !== 1'b1) rd_bad <= rd_bad + 1;
      if (wr_w[m] !== cs_w[m]) wr_bad <= wr_bad + 1;
      if (busy_w[m] && !prev_busy && tfirst < 0) tfirst <= cyc;
      if (done_w[m]) begin
        ndone <= ndone + 1;
        tdone <= cyc;
      end
    end
    prev_cs <= cs_w[m];
    prev_busy <= busy_w[m];
    prev_oe <= oe_w[m];
    prev_val <= {ad_w[m], bus_w[m]};
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 st[m] = 1'b1;
    @(posedge clk);
    #1 st[m] = 1'b0;
  endtask

  task automatic run_burst(input bit perturb);
    bit seen = 1'b0;
    pulse_start();
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      st[m] = 1'b0;
      if (perturb) begin
        if (c == 10 || c == 60) st[m] = 1'b1;
        if (sel_w[m] == 4'd3 && ad_w[m] && !cs_w[m]) ovr_en = 1'b1;
        else if (cs_w[m]) ovr_en = 1'b0;
      end
      if (done_w[m]) begin
        seen = 1'b1;
        check("busy_at_done", int'(busy_w[m]), 0);
        check("oe_at_done", int'(oe_w[m]), 0);
        if (perturb) st[m] = 1'b1;
      end
    end
    check("done_seen", int'(seen), 1);
    @(negedge clk);
    st[m] = 1'b0;
    ovr_en = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_after_burst", int'(busy_w[m]), 0);
  endtask

  task automatic check_burst(input int t);
    check("strobe_count", ns, 20);
    for (int k = 0; k < 20; k++) begin
      int it, a, d;
      it = k / 2;
      a = it == 9 ? 13 : 4 + it;
      d = it == 9 ? 240 : 16 + it;
      check($sformatf("phase%0d_t%0d", k, t), int'(cap[k]), (k % 2) ? 256 + d : a);
      check($sformatf("width%0d_t%0d", k, t), wid[k], t);
    end
    check("done_count", ndone, 1);
    check("burst_length", tdone - tfirst, 20 * (t + 2));
    check("rd_n_high", rd_bad, 0);
    check("wr_follows_cs", wr_bad, 0);
    check("bus_stability", stab_bad, 0);
  endtask

  initial begin
    st = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_cs_n", int'(cs_w[0]), 1);
    check("rst_wr_n", int'(wr_w[0]), 1);
    check("rst_rd_n", int'(rd_w[0]), 1);
    check("rst_bus_oe", int'(oe_w[0]), 0);
    check("rst_ad_sel", int'(ad_w[0]), 0);
    check("rst_busy", int'(busy_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);
    check("rst_bus_out", int'(bus_w[0]), 0);
    check("rst_sel_reg", int'(sel_w[0]), 0);
    st = 3'b000;
    rst_n = 1'b1;
    m = 0;
    clear_mon();
    run_burst(1'b0);
    check_burst(4);
    clear_mon();
    run_burst(1'b1);
    check_burst(4);
    clear_mon();
    pulse_start();
    for (int c = 0; c < 200 && !(sel_w[0] == 4'd5 && !cs_w[0]); c++) @(negedge clk);
    check("reach_item5_strobe", int'(sel_w[0] == 4'd5 && !cs_w[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", int'(cs_w[0]), 1);
    check("midrst_wr_n", int'(wr_w[0]), 1);
    check("midrst_bus_oe", int'(oe_w[0]), 0);
    check("midrst_busy", int'(busy_w[0]), 0);
    check("midrst_done", int'(done_w[0]), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_done", ndone, 0);
    check("midrst_stays_idle", int'(busy_w[0]), 0);
    clear_mon();
    run_burst(1'b0);
    check_burst(4);
    m = 1;
    clear_mon();
    run_burst(1'b0);
    check_burst(1);
    m = 2;
    clear_mon();
    run_burst(1'b0);
    check_burst(15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/rtc_write_sequencer.md
# rtc_write_sequencer

Write-side bus sequencer for the multiplexed address/data RTC interface; the counterpart of the read step decoder. On a start pulse it writes nine time/date registers (RTC addresses 0x4–0xC), then a transfer command to address 0xD, each as an address phase followed by a data phase with full CS/WR strobing. It sits between the register bank, which supplies data through `sel_reg`/`data_in`, and the RTC pins, sharing the bus with the read path under the top-level controller's arbitration.

## Interface
- `T_STROBE`, 4: cycles that CS#/WR# stay low per phase (legal range 1–15).
- `CMD`, 8'hF0: data byte written to address 0xD as the final item.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to start a write burst; sampled only in IDLE.
- `data_in`  in  8  register-bank byte selected by `sel_reg`; combinational from the bank.
- `sel_reg`  out  4  register-bank index 0–8 for items 0–8; 4'hF during item 9.
- `bus_out`  out  8  AD bus drive value.
- `bus_oe`  out  1  AD bus output enable (1 = drive).
- `ad_sel`  out  1  A/D pin: 0 = address phase, 1 = data phase.
- `cs_n`, `wr_n`, `rd_n`  out  1 each  active-low strobes; `rd_n` is constant 1.
- `busy`  out  1  high from start acceptance through the last HOLD.
- `done`  out  1  one-cycle pulse after the last phase.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- Registers: `item` (0–9), `phase` (0 = address, 1 = data), `cnt` (strobe counter), latched data byte.
- Item k: address 0x4+k for k = 0–8, and 0xD for k = 9. Data for k ≤ 8 is `data_in` with `sel_reg` = k. Data for k = 9 is `CMD`.
- IDLE: all strobes high, `bus_oe` = 0. When `start` = 1: `item` ← 0, `phase` ← 0, go to SETUP, `busy` ← 1.
- SETUP (1 cycle):
  - `bus_oe` = 1, `cs_n` = `wr_n` = 1, `ad_sel` = `phase`.
  - `bus_out` = {4'h0, addr} in the address phase, or the data byte in the data phase.
  - The data byte is latched from `data_in` on entry to the data-phase SETUP. `sel_reg` is already stable from the address phase of the same item.
- STROBE (`T_STROBE` cycles): `cs_n` = `wr_n` = 0. Bus and `ad_sel` held. `cnt` counts 0..T_STROBE−1.
- HOLD (1 cycle): `cs_n` = `wr_n` = 1, bus still driven and held.
- After HOLD:
  - phase 0: set phase 1, go to SETUP.
  - phase 1 with `item` < 9: increment `item`, set phase 0, go to SETUP.
  - phase 1 with `item` = 9: go to DONE.
- DONE (1 cycle): `done` = 1, `busy` = 0, `bus_oe` = 0. Return to IDLE.
- Boundary conditions:
  - `start` outside IDLE, including during DONE, is ignored; there is no queuing.
  - `start` held high continuously starts a new burst on each IDLE cycle.
  - `data_in` changes after the latch point have no effect on the current phase.
- Reset: when `reset` = 0 at a clock edge, the block is in IDLE with reset values on the next cycle, including mid-strobe. No trailing strobe is generated.

## Timing
- Reset values:
  - `cs_n` = `wr_n` = `rd_n` = 1.
  - `bus_oe` = `ad_sel` = `busy` = `done` = 0.
  - `bus_out` = 8'h00, `sel_reg` = 4'h0.
- All outputs are registered; no combinational path from `start` or `data_in` to the pins.
- `start` sampled at edge E: first SETUP (address 0x04 driven) is visible in cycle E+1.
- Each phase lasts `T_STROBE`+2 cycles. A burst of 20 phases lasts 20·(`T_STROBE`+2) cycles, i.e. 120 at the default.
- `done` is high exactly one cycle, immediately after the final HOLD. The earliest next `start` is accepted the cycle after DONE.
- The bus is stable for 1 cycle before CS# falls and 1 cycle after CS# rises. `ad_sel` never changes while `cs_n` = 0.

## Test plan
- Reset check: drive `reset` = 0 for 3 cycles with `start` = 1 -> all outputs at reset values, `busy` = 0.
- Nominal burst: bank holds 8'h10+k, pulse `start` -> 20 write strobes are captured.
  - Pairs are (addr 0x4+k, data 8'h10+k) for k = 0..8, then (0x0D, 8'hF0).
  - Each strobe is low 4 cycles; `done` pulses at cycle 120 after start; `rd_n` stays 1 throughout.
- Data latch: change `data_in` during the data-phase STROBE of item 3 -> the captured byte is the value present at that phase's SETUP entry.
- Ignored start: pulse `start` at cycles 10, 60 and during DONE -> exactly one burst, one `done` pulse.
- Reset mid-op: assert `reset` = 0 while `cs_n` = 0 in item 5.
  - Next cycle `cs_n` = `wr_n` = 1, `bus_oe` = 0, `busy` = 0, and no `done` pulse.
  - A new `start` then begins again at address 0x04.
- Parameter sweep: `T_STROBE` = 1 and 15 -> strobe widths of 1 and 15 cycles, bursts of 60 and 340 cycles, same address/data sequence.
